tt_um_tdm_demux4: RTL and testbench
===================================

TT_UM_TDM_DEMUX4 -- requirements
Module: tt_um_tdm_demux4

Interface
REQ-001 The block SHALL have the following ports:
- clk: input, 1 bit, single clock; all state is rising-edge.
- rst_n: input, 1 bit, asynchronous active-low reset.
- ena: input, 1 bit; high = design selected; low = input strobes ignored.
- ui_in: input, 8 bits.
  - [3:0] slot data nibble.
  - [4] frame sync.
  - [5] data valid.
  - [7:6] read channel select.
- uo_out: output, 8 bits.
  - [3:0] selected channel nibble.
  - [4] frame_done pulse.
  - [5] sync error flag.
  - [7:6] current slot.
- uio_in: input, 8 bits; unused.
- uio_out: output, 8 bits; completed-frame counter.
- uio_oe: output, 8 bits; constant 8'hFF.

Function
REQ-002 The block SHALL demultiplex a 4-slot TDM nibble stream into four 4-bit channels, ch0..ch3, using a 2-bit slot counter.
REQ-003 An input strobe SHALL be a clock edge where ena=1 and ui_in[5]=1. Edges without a strobe SHALL leave all state unchanged, except that frame_done clears.
REQ-004 Strobe with sync=1: ui_in[3:0] SHALL be written to shadow register 0, and slot SHALL become 1.
REQ-005 Strobe with sync=0: ui_in[3:0] SHALL be written to shadow[slot], and slot SHALL increment modulo 4.
REQ-006 A strobe with sync=1 and no valid SHALL be ignored.
REQ-007 A strobe that writes slot 3 SHALL complete the frame, with these effects at that same edge:
- all four output registers load {shadow0, shadow1, shadow2, ui_in[3:0]}; the slot-3 nibble is bypassed in.
- frame counter increments, wrapping 8'hFF to 8'h00.
- slot becomes 0.
REQ-008 frame_done (uo_out[4]) SHALL be high for exactly the one cycle following a frame-completing edge. Back-to-back frames SHALL produce one pulse per frame.
REQ-009 Output registers SHALL change only on frame completion. A partial frame SHALL never be visible on outputs.
REQ-010 uo_out[3:0] SHALL combinationally show the output register selected by ui_in[7:6], with zero latency.
REQ-011 uo_out[7:6] SHALL show the current slot counter. uio_out SHALL show the frame counter.
REQ-012 A strobe with sync=1 while slot≠0 SHALL:
- discard the partial frame (shadow contents are not transferred);
- restart the frame at slot 0 per REQ-004.
REQ-013 Slot 0 SHALL be accepted without sync; sync is a realignment aid, not mandatory.
REQ-014 ena=0 SHALL freeze the slot counter, shadows, outputs and counters. frame_done SHALL still clear after its one cycle.

Reset
REQ-015 rst_n low SHALL asynchronously clear all of the following to 0, irrespective of clk:
- slot counter.
- all shadow and output registers.
- frame counter.
- frame_done.
- error flag.
REQ-016 Reset asserted mid-frame SHALL discard the partial frame. The first strobe after release SHALL be treated as slot 0.
REQ-017 Release of rst_n SHALL take effect at the next rising clk edge, with no spurious frame_done.

Configuration
REQ-018 Macro TDM_SYNC_CHECK_EN SHALL control the error flag.
- Defined: uo_out[5] sets on any REQ-012 event and stays high until reset.
- Undefined: uo_out[5] is constant 0 and no error logic is built. REQ-012 realignment still applies.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset, then strobe nibbles A,B,C,D with sync on the first, and sel=2.
  - Required: frame_done pulses once.
  - Required: uo_out[3:0]=C and uio_out=8'h01.
  - Required: sel 0..3 reads A,B,C,D.
- Strobe 1,2 (sync on 1), then hold valid low 5 cycles, then strobe 3,4.
  - Required: outputs stay 0 until the edge of 4.
  - Required: then channels read 1,2,3,4, with one frame_done.
- Strobe 5,6 (sync on 5), then sync+7, then 8,9,A.
  - Required: channels read 7,8,9,A.
  - Required: frame counter increments once.
  - Required: uo_out[5]=1 with TDM_SYNC_CHECK_EN defined, 0 without.
- Run 256 complete back-to-back frames.
  - Required: 256 single-cycle frame_done pulses.
  - Required: uio_out wraps to 8'h00.
- Strobe 1,2,3, then pulse rst_n low between clock edges.
  - Required: all outputs are 0 immediately.
  - Required: the next strobe (nibble F, no sync) lands in ch0 slot; uo_out[7:6]=1 after it.
- Hold ena=0 and strobe 4 nibbles.
  - Required: no state change.
  - Required: uio_oe reads 8'hFF throughout.

Source files
------------

// File: rtl/tt_um_tdm_demux4.sv
// tt_um_tdm_demux4: 4-slot TDM nibble demultiplexer.
// A 2-bit slot counter steers incoming nibbles into shadow registers. The
// fourth nibble of a frame, together with the three shadows, loads all four
// channel output registers at once. A partial frame therefore never reaches
// the outputs.
// Optional feature: define TDM_SYNC_CHECK_EN to build a sticky sync-error
// flag on uo_out[5]. The flag sets when a sync strobe arrives mid-frame.
module tt_um_tdm_demux4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  slot_e       slot_q, slot_d;
  logic [3:0]  shadow0, shadow1, shadow2;
  logic [3:0]  ch [4];
  logic [7:0]  frame_cnt;
  logic        frame_done;
  logic        err;

  logic [3:0]  nib;
  logic        sync;
  logic        strobe;
  logic [2:0]  wr_sh;
  logic        complete;

  logic        unused_bits;
  assign unused_bits = &{1'b0, uio_in};

  assign nib    = ui_in[3:0];
  assign sync   = ui_in[4];
  assign strobe = ena & ui_in[5];

  // Slot state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= SLOT0;
    else        slot_q <= slot_d;
  end

  // Next slot and write enables: sync restarts at slot 0; slot 3 completes the frame.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    slot_d   = slot_q;
    wr_sh    = 3'b000;
    complete = 1'b0;
    if (strobe) begin
      if (sync) begin
        wr_sh[0] = 1'b1;
        slot_d   = SLOT1;
      end else begin
        unique case (slot_q)
          SLOT0: begin wr_sh[0] = 1'b1; slot_d = SLOT1; end
          SLOT1: begin wr_sh[1] = 1'b1; slot_d = SLOT2; end
          SLOT2: begin wr_sh[2] = 1'b1; slot_d = SLOT3; end
          SLOT3: begin complete = 1'b1; slot_d = SLOT0; end
          default: slot_d = SLOT0;
        endcase
      end
    end
  end

  // Shadow capture for slots 0..2. Slot 3 bypasses straight into the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0 <= 4'h0;
      shadow1 <= 4'h0;
      shadow2 <= 4'h0;
    end else begin
      if (wr_sh[0]) shadow0 <= nib;
      if (wr_sh[1]) shadow1 <= nib;
      if (wr_sh[2]) shadow2 <= nib;
    end
  end

  // Channel registers load as a group on frame completion.
  // NOTE: this 4-entry register file is reset because outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ch[i] <= 4'h0;
    end else if (complete) begin
      ch[0] <= shadow0;
      ch[1] <= shadow1;
      ch[2] <= shadow2;
      ch[3] <= nib;
    end
  end

  // Frame counter wraps naturally at 8 bits. frame_done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= complete;
      if (complete) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef TDM_SYNC_CHECK_EN
  logic realign;
  assign realign = strobe & sync & (slot_q != SLOT0);

  // Sticky error flag: set by any mid-frame sync realignment, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (realign) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  logic [3:0] sel_nib;

  // Zero-latency read mux over the channel registers.
  always_comb begin
    sel_nib = 4'h0;
    unique case (ui_in[7:6])
      2'd0: sel_nib = ch[0];
      2'd1: sel_nib = ch[1];
      2'd2: sel_nib = ch[2];
      2'd3: sel_nib = ch[3];
      default: sel_nib = 4'h0;
    endcase
  end

  assign uo_out  = {slot_q, err, frame_done, sel_nib};
  assign uio_out = frame_cnt;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_tdm_demux4.sv
// Directed bench for tt_um_tdm_demux4.
// A vector table covers the basic frame. Hand-written sequences cover
// gaps, realignment, counter wrap, mid-frame reset and ena=0.
module tb_tt_um_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

`ifdef TDM_SYNC_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    logic       e;
    logic       v;
    logic       s;
    logic [3:0] nib;
    logic [1:0] sel;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[8];

  tt_um_tdm_demux4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
  task automatic step(input logic e, input logic v, input logic s,
                      input logic [3:0] nib, input logic [1:0] sel);
    @(negedge clk);
    ena   = e;
    ui_in = {sel, v, s, nib};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ena   = 1'b1;
    ui_in = 8'h00;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int pulses;
  int bad;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;

    // Scenario 1: A,B,C,D with sync on A, then read every channel.
    // uo_out = {slot, err, frame_done, channel nibble}.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 4'hA, 2'd2, 8'h40, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'hB, 2'd2, 8'h80, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hC, 2'd2, 8'hC0, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hD, 2'd2, 8'h1C, 8'h01};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 8'h0A, 8'h01};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd1, 8'h0B, 8'h01};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 8'h0C, 8'h01};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd3, 8'h0D, 8'h01};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].e, vecs[i].v, vecs[i].s, vecs[i].nib, vecs[i].sel);
      check($sformatf("s1_uo[%0d]", i), uo_out, vecs[i].exp_uo);
      check($sformatf("s1_uio[%0d]", i), uio_out, vecs[i].exp_uio);
    end

    // Scenario 2: a gap with valid low, including sync-without-valid, is ignored.
    do_reset();
    step(1, 1, 1, 4'h1, 2'd0);
    check("s2_slot1", uo_out, 8'h40);
    step(1, 1, 0, 4'h2, 2'd0);
    check("s2_slot2", uo_out, 8'h80);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, i[0], 4'hF, i[1:0]);
      check($sformatf("s2_gap[%0d]", i), uo_out, 8'h80);
    end
    step(1, 1, 0, 4'h3, 2'd0);
    check("s2_slot3", uo_out, 8'hC0);
    check("s2_uio_pre", uio_out, 8'h00);
    step(1, 1, 0, 4'h4, 2'd3);
    check("s2_done", uo_out, 8'h14);
    check("s2_uio", uio_out, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 4'h0, i[1:0]);
      check($sformatf("s2_ch%0d", i), uo_out, {4'h0, 4'(i + 1)});
    end

    // Scenario 3: a sync arrives mid-frame, so the frame realigns onto 7.
    do_reset();
    step(1, 1, 1, 4'h5, 2'd0);
    step(1, 1, 0, 4'h6, 2'd0);
    step(1, 1, 1, 4'h7, 2'd0);
    check("s3_realign_slot", uo_out[7:6], 2'd1);
    check("s3_err", uo_out[5], ERR_EN);
    step(1, 1, 0, 4'h8, 2'd0);
    step(1, 1, 0, 4'h9, 2'd0);
    check("s3_uio_pre", uio_out, 8'h00);
    step(1, 1, 0, 4'hA, 2'd0);
    check("s3_done", uo_out, {2'b00, ERR_EN, 1'b1, 4'h7});
    check("s3_uio", uio_out, 8'h01);
    for (int i = 1; i < 4; i++) begin
      step(1, 0, 0, 4'h0, i[1:0]);
      check($sformatf("s3_ch%0d", i), uo_out, {2'b00, ERR_EN, 1'b0, 4'(i + 7)});
    end

    // Scenario 4: 256 back-to-back frames wrap the frame counter.
    do_reset();
    pulses = 0;
    bad    = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, 1, (k == 0) && !f[0], 4'(f + k), 2'd3);
        if (uo_out[4]) pulses++;
        if (uo_out[4] !== (k == 3)) bad++;
        if (k == 3 && uo_out[3:0] !== 4'(f + 3)) bad++;
      end
      if (uio_out !== 8'(f + 1)) bad++;
    end
    check("s4_pulses", pulses, 256);
    check("s4_bad", bad, 0);
    check("s4_uio_wrap", uio_out, 8'h00);

    // Scenario 5: partial frame, then an asynchronous reset between edges.
    step(1, 1, 1, 4'h1, 2'd0);
    step(1, 1, 0, 4'h2, 2'd0);
    step(1, 1, 0, 4'h3, 2'd0);
    check("s5_partial_hidden", uo_out, 8'hCF);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ui_in = {i[1:0], 6'h00};
      #1;
      check($sformatf("s5_rst_uo_sel%0d", i), uo_out, 8'h00);
    end
    check("s5_rst_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    step(1, 1, 0, 4'hF, 2'd0);
    check("s5_first_slot", uo_out, 8'h40);
    step(1, 1, 0, 4'h1, 2'd0);
    step(1, 1, 0, 4'h2, 2'd0);
    step(1, 1, 0, 4'h3, 2'd0);
    check("s5_done_ch0", uo_out, 8'h1F);
    check("s5_uio", uio_out, 8'h01);

    // Scenario 6: with ena low, strobes change nothing and frame_done still clears.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (i == 0), 4'(i + 4), i[1:0]);
      check($sformatf("s6_uo[%0d]", i), uo_out,
            {4'h0, (i == 0) ? 4'hF : 4'(i)});
      check($sformatf("s6_uio[%0d]", i), uio_out, 8'h01);
      check($sformatf("s6_oe[%0d]", i), uio_oe, 8'hFF);
    end
    step(1, 0, 0, 4'h0, 2'd0);
    check("s6_after", uo_out, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
